// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types for the push-button scanner.
// Channel FSM encoding and debounce/hold counter widths.
package key_scan_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DEB   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    RELEASE_DEB = 3'd4
  } ch_state_e;

  localparam int DEB_W  = 10;
  localparam int HOLD_W = 16;

endpackage

// File: rtl/key_channel.sv
// key_channel: one button - 2-flop sync, debounce FSM, hold timer.
// Ports: clk, rst_n, pin (raw) -> key_state and four 1-cycle pulses.
module key_channel
  import key_scan_pkg::*;
#(
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = 655,
  parameter int LONG_TICKS     = 32768,
  parameter int REPEAT_TICKS   = 8192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [DEB_W-1:0] DEB_MAX =
    DEB_W'(DEBOUNCE_TICKS);
  localparam logic [HOLD_W-1:0] LONG_LIM =
    HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LIM =
    HOLD_W'(REPEAT_TICKS - 1);
  // Synchroniser idles at the released pin level.
  localparam logic SYNC_RST = ACTIVE_LOW;

  logic [1:0]        sync;
  logic              raw_p;
  ch_state_e         state;
  ch_state_e         ret;
  logic [DEB_W-1:0]  deb;
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{SYNC_RST}};
    end else begin
      sync <= {sync[0], pin};
    end
  end

  assign raw_p = ACTIVE_LOW ? ~sync[1] : sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ret           <= HELD;
      deb           <= '0;
      hold          <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (raw_p) begin
            state <= PRESS_DEB;
            deb   <= DEB_W'(1);
          end
        end
        PRESS_DEB: begin
          if (!raw_p) begin
            state <= IDLE;
            deb   <= '0;
          end else if (deb >= DEB_MAX) begin
            state       <= HELD;
            key_state   <= 1'b1;
            press_pulse <= 1'b1;
            hold        <= '0;
            deb         <= '0;
          end else if (deb != '1) begin
            deb <= deb + 1'b1;
          end
        end
        HELD: begin
          if (!raw_p) begin
            state <= RELEASE_DEB;
            ret   <= HELD;
            deb   <= DEB_W'(1);
          end else if (hold == LONG_LIM) begin
            state      <= REPEAT;
            long_pulse <= 1'b1;
            hold       <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        REPEAT: begin
          if (!raw_p) begin
            state <= RELEASE_DEB;
            ret   <= REPEAT;
            deb   <= DEB_W'(1);
          end else if (hold == REP_LIM) begin
            repeat_pulse <= 1'b1;
            hold         <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        RELEASE_DEB: begin
          // Hold count is frozen so a glitch resumes timing.
          if (raw_p) begin
            state <= ret;
            deb   <= '0;
          end else if (deb >= DEB_MAX) begin
            state         <= IDLE;
            key_state     <= 1'b0;
            release_pulse <= 1'b1;
            deb           <= '0;
            hold          <= '0;
          end else if (deb != '1) begin
            deb <= deb + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_scan.sv
// key_scan: NUM_KEYS debounced buttons for the watch controls.
// Ports: clk_32_768K, rst_n, Button_IN -> key_state and pulse buses.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = 655,
  parameter int LONG_TICKS     = 32768,
  parameter int REPEAT_TICKS   = 8192
) (
  input  logic                clk_32_768K,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] Button_IN,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  if (DEBOUNCE_TICKS < 1 ||
      DEBOUNCE_TICKS >= (1 << DEB_W) ||
      LONG_TICKS <= DEBOUNCE_TICKS ||
      LONG_TICKS > (1 << HOLD_W) ||
      REPEAT_TICKS < 1 ||
      REPEAT_TICKS > (1 << HOLD_W)) begin : g_bad_params
    $error("key_scan: illegal tick parameters");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk           (clk_32_768K),
      .rst_n         (rst_n),
      .pin           (Button_IN[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule
